// File: rtl/fpu_fma_issuer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fpu_fma_issuer
//
// Initiator side of the FPU start/done handshake for fused multiply-add.
// A request accepted on the valid/ready request channel has its rounding
// mode resolved (static rm or dynamic fcsr.frm). The issuer then pulses
// unit_start to a single FMA unit and waits for unit_done. The result and
// inexact flag are returned on a valid/ready response channel.
// An illegal rounding mode short-circuits to an error response without
// touching the unit. A watchdog aborts a WAIT that lasts TIMEOUT cycles.
// A sticky NX bit accumulates inexact results for fcsr.fflags.
//
// Parameters
//   TAG_W    width of the opaque request/response tag
//   TIMEOUT  maximum WAIT cycles before abort with err=2'b10 (>= 2)
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_operA/B/C       binary32 multiplicand, multiplier, addend
//   req_opcode          00 fmadd, 01 fmsub, 10 fnmsub, 11 fnmadd
//   req_rm              instruction rounding mode, 3'b111 = dynamic
//   req_tag             opaque tag, echoed on the response
//   csr_frm             fcsr.frm, sampled when the request is accepted
//   unit_start          one-cycle start pulse to the FMA unit
//   unit_operA/B/C      registered operands to the unit
//   unit_opcode         registered opcode to the unit
//   unit_frm            resolved rounding mode to the unit
//   unit_rd             unit result, valid with unit_done
//   unit_flag_nx        unit inexact flag, valid with unit_done
//   unit_done           unit completion pulse
//   rsp_valid/ready     response handshake
//   rsp_result          result (canonical qNaN on error)
//   rsp_tag             tag of the request
//   rsp_nx              inexact flag of this operation
//   rsp_err             00 ok, 01 illegal rm, 10 timeout
//   fflags_nx           sticky inexact accumulator
//   fflags_clr          clears fflags_nx (a same-cycle set wins)
//   busy                high in every state except idle
// -----------------------------------------------------------------------------
module fpu_fma_issuer #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_operA,
  input  logic [31:0]      req_operB,
  input  logic [31:0]      req_operC,
  input  logic [1:0]       req_opcode,
  input  logic [2:0]       req_rm,
  input  logic [TAG_W-1:0] req_tag,
  input  logic [2:0]       csr_frm,

  output logic             unit_start,
  output logic [31:0]      unit_operA,
  output logic [31:0]      unit_operB,
  output logic [31:0]      unit_operC,
  output logic [1:0]       unit_opcode,
  output logic [2:0]       unit_frm,
  input  logic [31:0]      unit_rd,
  input  logic             unit_flag_nx,
  input  logic             unit_done,

  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_nx,
  output logic [1:0]       rsp_err,

  output logic             fflags_nx,
  input  logic             fflags_clr,
  output logic             busy
);

  localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]     QNAN     = 32'h7FC0_0000;
  localparam logic [1:0]      ERR_OK   = 2'b00;
  localparam logic [1:0]      ERR_RM   = 2'b01;
  localparam logic [1:0]      ERR_TO   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic [2:0] rm_res;
  logic       bad_rm;
  logic       accept;
  logic       done_cap;
  logic       timed_out;

  // Dynamic rounding mode (3'b111) defers to fcsr.frm.
  function automatic logic [2:0] resolve_rm(input logic [2:0] rm,
                                            input logic [2:0] frm);
    return (rm == 3'b111) ? frm : rm;
  endfunction

  // Encodings 101..111 are reserved once the mode has been resolved.
  function automatic logic rm_illegal(input logic [2:0] rm);
    return (rm == 3'b101) || (rm == 3'b110) || (rm == 3'b111);
  endfunction

  assign rm_res    = resolve_rm(req_rm, csr_frm);
  assign bad_rm    = rm_illegal(rm_res);
  assign accept    = (state == S_IDLE) && req_valid;
  // A done pulse only counts while waiting; late pulses are dropped.
  assign done_cap  = (state == S_WAIT) && unit_done;
  // done in the final wait cycle takes priority over the watchdog.
  assign timed_out = (state == S_WAIT) && !unit_done && (wait_cnt == CNT_LAST);

  // Handshake outputs decode registered state only, so rsp_valid never
  // depends combinationally on rsp_ready.
  assign req_ready  = (state == S_IDLE);
  assign unit_start = (state == S_ISSUE);
  assign rsp_valid  = (state == S_RESP);
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_valid) state_nxt = bad_rm ? S_RESP : S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (done_cap || timed_out) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Watchdog: zeroed in ISSUE, so it reads 0 in the first WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Request capture: operands stay stable from ISSUE through WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unit_operA  <= '0;
      unit_operB  <= '0;
      unit_operC  <= '0;
      unit_opcode <= '0;
      unit_frm    <= '0;
      rsp_tag     <= '0;
    end else if (accept) begin
      unit_operA  <= req_operA;
      unit_operB  <= req_operB;
      unit_operC  <= req_operC;
      unit_opcode <= req_opcode;
      rsp_tag     <= req_tag;
      if (!bad_rm) begin
        unit_frm <= rm_res;
      end
    end
  end

  // Response capture: written once per request and held through RESP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_result <= '0;
      rsp_nx     <= 1'b0;
      rsp_err    <= ERR_OK;
    end else if (accept && bad_rm) begin
      rsp_result <= QNAN;
      rsp_nx     <= 1'b0;
      rsp_err    <= ERR_RM;
    end else if (done_cap) begin
      rsp_result <= unit_rd;
      rsp_nx     <= unit_flag_nx;
      rsp_err    <= ERR_OK;
    end else if (timed_out) begin
      rsp_result <= QNAN;
      rsp_nx     <= 1'b0;
      rsp_err    <= ERR_TO;
    end
  end

  // Sticky inexact: a capture with NX set overrides a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fflags_nx <= 1'b0;
    end else if (done_cap && unit_flag_nx) begin
      fflags_nx <= 1'b1;
    end else if (fflags_clr) begin
      fflags_nx <= 1'b0;
    end
  end

endmodule
